// File: rtl/rstgen_seq.sv
// rstgen_seq
// ----------
// PLL-lock-qualified reset sequencer for NUM_CH reset domains sharing one clock.
// The asynchronous PLL lock is synchronised and debounced, all domains are held
// in reset for a programmable minimum time, and then the domains are released
// one at a time in channel order (bit 0 first) with a fixed stagger. The block
// re-enters reset on a software request and, optionally, on PLL lock loss.
//
// Parameters:
//   NUM_CH         number of reset outputs (>=1)
//   SYNC_DEPTH     lock synchroniser flops (>=2)
//   LOCK_FILTER    consecutive synced-high cycles needed to accept lock (>=1)
//   HOLD_CYCLES    minimum all-in-reset cycles before the first release (>=1)
//   STAGGER_CYCLES cycles between successive channel releases (>=1)
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   lock_i       PLL locked, asynchronous to clk_i
//   test_mode_i  DFT bypass: rst_no follows ~rst_i combinationally, busy_o=0
//   sw_rst_i     single-cycle software reset request
//   lost_clr_i   clears the sticky lock-lost flag
//   rst_no       active-low domain resets, bit 0 released first
//   busy_o       high while any domain is still in reset
//   lock_lost_o  sticky flag: lock dropped while every domain was running
//
// Build option:
//   RSTGEN_SEQ_LOCKLOSS_EN  when defined, losing lock during RELEASE/RUN puts
//   every domain back into reset and sets lock_lost_o. When undefined, lock is
//   ignored once the first release has happened, lock_lost_o stays 0, and a
//   software request goes back through HOLD without rechecking lock.

module rstgen_seq #(
   parameter int NUM_CH         = 3,
   parameter int SYNC_DEPTH     = 2,
   parameter int LOCK_FILTER    = 4,
   parameter int HOLD_CYCLES    = 8,
   parameter int STAGGER_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lock_i,
   input  logic              test_mode_i,
   input  logic              sw_rst_i,
   input  logic              lost_clr_i,
   output logic [NUM_CH-1:0] rst_no,
   output logic              busy_o,
   output logic              lock_lost_o
);

   localparam int FILT_W = $clog2(LOCK_FILTER + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);

   typedef enum logic [1:0] {
      WAIT_LOCK,
      HOLD,
      RELEASE,
      RUN
   } state_e;

   state_e              state_q;
   logic [SYNC_DEPTH-1:0] sync_q;
   logic [SYNC_DEPTH-1:0] sync_d;
   logic [FILT_W-1:0]   filtCnt_q;
   logic [HOLD_W-1:0]   holdCnt_q;
   logic [STAG_W-1:0]   stagCnt_q;
   logic [NUM_CH-1:0]   rstN_q;
   logic [NUM_CH-1:0]   relNext;
   logic                busy_q;
   logic                lost_q;
   logic                lockS;
   logic                lockDropHold;
   logic                lockDropLate;

   // Lock synchroniser: lock_i shifts in at bit 0, the oldest bit is the
   // metastability-safe lock_s used by everything else.
   assign sync_d = {sync_q[SYNC_DEPTH-2:0], lock_i};
   assign lockS  = sync_q[SYNC_DEPTH-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

`ifdef RSTGEN_SEQ_LOCKLOSS_EN
   // Lock loss aborts the sequence in every state past WAIT_LOCK.
   assign lockDropHold = ~lockS;
   assign lockDropLate = ~lockS;
`else
   logic everRel_q;

   // Remembers that the domains have been released at least once since reset.
   // After that, lock is no longer looked at, so a HOLD entered through a
   // software request runs to completion even if lock is low.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         everRel_q <= 1'b0;
      end else if (state_q == RELEASE || state_q == RUN) begin
         everRel_q <= 1'b1;
      end
   end

   assign lockDropHold = ~lockS & ~everRel_q;
   assign lockDropLate = 1'b0;
`endif

   // Next release pattern: one more low-order bit set, so bits can only rise
   // in channel order.
   assign relNext = (rstN_q << 1) | NUM_CH'(1);

   // Main sequencer. Every functional output is a register written here, so
   // the rst_no/busy_o pair always changes on the same edge. All counters are
   // cleared when their state is left and stop at their terminal count, so
   // none of them can wrap.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= WAIT_LOCK;
         filtCnt_q <= '0;
         holdCnt_q <= '0;
         stagCnt_q <= '0;
         rstN_q    <= '0;
         busy_q    <= 1'b1;
         lost_q    <= 1'b0;
      end else begin
         // A set of the sticky flag beats a clear arriving in the same cycle.
         if (state_q == RUN && lockDropLate) begin
            lost_q <= 1'b1;
         end else if (lost_clr_i) begin
            lost_q <= 1'b0;
         end

         case (state_q)
            WAIT_LOCK: begin
               rstN_q <= '0;
               busy_q <= 1'b1;
               if (!lockS) begin
                  filtCnt_q <= '0;
               end else if (filtCnt_q == FILT_W'(LOCK_FILTER - 1)) begin
                  filtCnt_q <= '0;
                  holdCnt_q <= '0;
                  state_q   <= HOLD;
               end else begin
                  filtCnt_q <= filtCnt_q + 1'b1;
               end
            end

            HOLD: begin
               if (lockDropHold) begin
                  holdCnt_q <= '0;
                  filtCnt_q <= '0;
                  state_q   <= WAIT_LOCK;
               end else if (sw_rst_i) begin
                  holdCnt_q <= '0;
               end else if (holdCnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                  holdCnt_q <= '0;
                  stagCnt_q <= '0;
                  rstN_q    <= NUM_CH'(1);
                  if (NUM_CH == 1) begin
                     busy_q  <= 1'b0;
                     state_q <= RUN;
                  end else begin
                     state_q <= RELEASE;
                  end
               end else begin
                  holdCnt_q <= holdCnt_q + 1'b1;
               end
            end

            RELEASE: begin
               if (lockDropLate) begin
                  stagCnt_q <= '0;
                  filtCnt_q <= '0;
                  rstN_q    <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= WAIT_LOCK;
               end else if (sw_rst_i) begin
                  stagCnt_q <= '0;
                  holdCnt_q <= '0;
                  rstN_q    <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= HOLD;
               end else if (stagCnt_q == STAG_W'(STAGGER_CYCLES - 1)) begin
                  stagCnt_q <= '0;
                  rstN_q    <= relNext;
                  if (&relNext) begin
                     busy_q  <= 1'b0;
                     state_q <= RUN;
                  end
               end else begin
                  stagCnt_q <= stagCnt_q + 1'b1;
               end
            end

            RUN: begin
               if (lockDropLate) begin
                  filtCnt_q <= '0;
                  rstN_q    <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= WAIT_LOCK;
               end else if (sw_rst_i) begin
                  holdCnt_q <= '0;
                  rstN_q    <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= HOLD;
               end
            end

            default: begin
               state_q <= WAIT_LOCK;
            end
         endcase
      end
   end

   // DFT bypass: the only combinational path to the outputs. The FSM keeps
   // running underneath and takes over again when test_mode_i drops.
   assign rst_no      = test_mode_i ? {NUM_CH{~rst_i}} : rstN_q;
   assign busy_o      = test_mode_i ? 1'b0 : busy_q;
   assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_rstgen_seq.sv
// tb_rstgen_seq
// -------------
// Scoreboard bench for rstgen_seq. The stimulus process drives lock/sw/clear
// inputs, steps a behavioural reference model after each rising edge and
// pushes the expected outputs into a queue; an independent monitor pops one
// entry per falling edge and compares it with the DUT. The reference model
// works from elapsed edge counts (time since hold start, length of the current
// run of synchronised lock highs) instead of per-state counters.

module tb_rstgen_seq;

   localparam int NUM_CH         = 3;
   localparam int SYNC_DEPTH     = 2;
   localparam int LOCK_FILTER    = 4;
   localparam int HOLD_CYCLES    = 8;
   localparam int STAGGER_CYCLES = 2;
   localparam int LOCKUP         = SYNC_DEPTH + LOCK_FILTER + HOLD_CYCLES;

`ifdef RSTGEN_SEQ_LOCKLOSS_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic              clk         = 1'b0;
   logic              rst_i       = 1'b1;
   logic              lock_i      = 1'b0;
   logic              test_mode_i = 1'b0;
   logic              sw_rst_i    = 1'b0;
   logic              lost_clr_i  = 1'b0;
   logic [NUM_CH-1:0] rst_no;
   logic              busy_o;
   logic              lock_lost_o;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct packed {
      logic [NUM_CH-1:0] rstN;
      logic              busy;
      logic              lost;
   } expT;

   expT expQ[$];
   expT monExp;

   // Reference model state
   bit lockHist[$];
   int edgeN;
   bit active;
   int highRun;
   int holdStart;
   int released;
   bit everRel;
   bit lostExp;

   // Scenario bookkeeping
   int riseEdge[NUM_CH];
   int busyFall;
   int firstHit;
   int lockLvl;
   int lockLeft;

   rstgen_seq #(
      .NUM_CH         (NUM_CH),
      .SYNC_DEPTH     (SYNC_DEPTH),
      .LOCK_FILTER    (LOCK_FILTER),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .STAGGER_CYCLES (STAGGER_CYCLES)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .lock_i      (lock_i),
      .test_mode_i (test_mode_i),
      .sw_rst_i    (sw_rst_i),
      .lost_clr_i  (lost_clr_i),
      .rst_no      (rst_no),
      .busy_o      (busy_o),
      .lock_lost_o (lock_lost_o)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // Number of released channels after elapsed edges since hold start
   function automatic int relCount(input int el);
      int r;
      if (el < HOLD_CYCLES) return 0;
      r = 1 + (el - HOLD_CYCLES) / STAGGER_CYCLES;
      return (r > NUM_CH) ? NUM_CH : r;
   endfunction

   task automatic modelReset();
      lockHist.delete();
      edgeN     = 0;
      active    = 1'b0;
      highRun   = 0;
      holdStart = 0;
      released  = 0;
      everRel   = 1'b0;
      lostExp   = 1'b0;
   endtask

   // One rising edge of the reference model with the inputs sampled there.
   task automatic modelStep(input bit lockV, input bit swV, input bit clrV);
      bit  lockS;
      bit  setLost;
      int  prevRel;
      expT e;
      edgeN++;
      lockS = (lockHist.size() >= SYNC_DEPTH) ? lockHist[lockHist.size() - SYNC_DEPTH] : 1'b0;
      lockHist.push_back(lockV);
      prevRel = released;
      setLost = 1'b0;
      if (!active) begin
         highRun = lockS ? highRun + 1 : 0;
         if (highRun == LOCK_FILTER) begin
            active    = 1'b1;
            holdStart = edgeN;
            highRun   = 0;
         end
      end else if (!lockS && (LOSS_EN || !everRel)) begin
         active  = 1'b0;
         highRun = 0;
         setLost = (prevRel == NUM_CH);
      end else if (swV) begin
         holdStart = edgeN;
      end
      released = active ? relCount(edgeN - holdStart) : 0;
      if (released > 0) everRel = 1'b1;
      if (setLost) lostExp = 1'b1;
      else if (clrV) lostExp = 1'b0;
      e.rstN = NUM_CH'((1 << released) - 1);
      e.busy = (released < NUM_CH);
      e.lost = lostExp;
      expQ.push_back(e);
   endtask

   // Drive one cycle of inputs, step the model on the edge, return at negedge.
   task automatic applyStimulus(input bit lockV, input bit swV, input bit clrV);
      lock_i     = lockV;
      sw_rst_i   = swV;
      lost_clr_i = clrV;
      @(posedge clk);
      modelStep(lockV, swV, clrV);
      @(negedge clk);
   endtask

   task automatic resetDut(input bit lockV, input int n);
      @(negedge clk);
      #2;
      rst_i      = 1'b1;
      sw_rst_i   = 1'b0;
      lost_clr_i = 1'b0;
      lock_i     = lockV;
      #1;
      checkOutput("reset rst_no", 32'(rst_no), 0);
      checkOutput("reset busy_o", 32'(busy_o), 1);
      checkOutput("reset lock_lost_o", 32'(lock_lost_o), 0);
      repeat (n) @(posedge clk);
      @(negedge clk);
      checkOutput("held reset rst_no", 32'(rst_no), 0);
      checkOutput("held reset busy_o", 32'(busy_o), 1);
      #2;
      rst_i = 1'b0;
      modelReset();
   endtask

   // Monitor: one scoreboard entry per cycle of functional operation
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         checkOutput("sb rst_no", 32'(rst_no), 32'(monExp.rstN));
         checkOutput("sb busy_o", 32'(busy_o), 32'(monExp.busy));
         checkOutput("sb lock_lost_o", 32'(lock_lost_o), 32'(monExp.lost));
      end
   end

   initial begin
      $display("[TB] rstgen_seq bench start, lock-loss feature %0d", LOSS_EN);
      modelReset();

      // Power-up with lock already present: measure release edges
      resetDut(1'b1, 3);
      for (int k = 0; k < NUM_CH; k++) riseEdge[k] = -1;
      busyFall = -1;
      for (int n = 1; n <= LOCKUP + STAGGER_CYCLES * NUM_CH + 4; n++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         for (int k = 0; k < NUM_CH; k++)
            if (riseEdge[k] < 0 && rst_no[k]) riseEdge[k] = n;
         if (busyFall < 0 && !busy_o) busyFall = n;
      end
      for (int k = 0; k < NUM_CH; k++)
         checkOutput($sformatf("rise edge ch%0d", k), 32'(riseEdge[k]), 32'(LOCKUP + STAGGER_CYCLES * k));
      checkOutput("busy fall edge", 32'(busyFall), 32'(LOCKUP + STAGGER_CYCLES * (NUM_CH - 1)));

      // Short lock pulses must not release; latency counts from the final rise
      resetDut(1'b0, 2);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 2; g++) begin
         repeat ($urandom_range(1, LOCK_FILTER - 1)) applyStimulus(1'b1, 1'b0, 1'b0);
         repeat ($urandom_range(3, 6)) applyStimulus(1'b0, 1'b0, 1'b0);
      end
      firstHit = -1;
      for (int n = 1; n <= LOCKUP + STAGGER_CYCLES * NUM_CH + 4; n++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (firstHit < 0 && rst_no[0]) firstHit = n;
      end
      checkOutput("latency after glitches", 32'(firstHit), 32'(LOCKUP));

      // Lock drop while running
      firstHit = -1;
      for (int n = 1; n <= 6; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (firstHit < 0 && rst_no == '0) firstHit = n;
      end
      checkOutput("lock loss edge", 32'(firstHit), LOSS_EN ? 32'(SYNC_DEPTH + 1) : 32'hFFFF_FFFF);
      checkOutput("lock_lost_o after drop", 32'(lock_lost_o), 32'(LOSS_EN));
      repeat (LOCKUP + STAGGER_CYCLES * NUM_CH + 2) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("lock_lost_o after clear", 32'(lock_lost_o), 0);

      // Software request during RELEASE with only channel 0 out of reset
      resetDut(1'b1, 2);
      repeat (LOCKUP) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("pre sw rst_no", 32'(rst_no), 1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("sw rst_no", 32'(rst_no), 0);
      firstHit = -1;
      for (int n = 1; n <= HOLD_CYCLES + STAGGER_CYCLES * NUM_CH + 2; n++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (firstHit < 0 && rst_no[0]) firstHit = n;
      end
      checkOutput("sw re-release edge", 32'(firstHit), 32'(HOLD_CYCLES));
      checkOutput("sw lock_lost_o", 32'(lock_lost_o), 0);
      checkOutput("sw final rst_no", 32'(rst_no), 32'((1 << NUM_CH) - 1));

      // Randomised traffic: long lock-high runs with occasional drops,
      // sparse software requests and clears
      resetDut(1'b1, 2);
      lockLvl  = 1;
      lockLeft = 30;
      for (int i = 0; i < 900; i++) begin
         if (lockLeft == 0) begin
            lockLvl  = (lockLvl == 0 || $urandom_range(0, 3) == 0) ? 1 : 0;
            lockLeft = lockLvl ? $urandom_range(1, 50) : $urandom_range(1, 6);
         end
         lockLeft--;
         applyStimulus(lockLvl[0], $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      end

      // DFT bypass: rst_no follows ~rst_i combinationally, busy_o forced low
      @(negedge clk);
      #2;
      test_mode_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rst_i = ~rst_i;
         #1;
         checkOutput("test rst_no", 32'(rst_no), rst_i ? 0 : 32'((1 << NUM_CH) - 1));
         checkOutput("test busy_o", 32'(busy_o), 0);
         #($urandom_range(2, 12));
      end
      rst_i       = 1'b1;
      test_mode_i = 1'b0;
      #1;
      checkOutput("leave test rst_no", 32'(rst_no), 0);
      checkOutput("leave test busy_o", 32'(busy_o), 1);

      // Normal operation resumes after the bypass
      resetDut(1'b1, 2);
      repeat (LOCKUP + STAGGER_CYCLES * NUM_CH + 2) applyStimulus(1'b1, 1'b0, 1'b0);

      @(negedge clk);
      #2;
      checkOutput("scoreboard drained", 32'(expQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
